seg_capture: RTL and testbench
==============================

Name: seg_capture

Overview:
- Inverse of the team's multiplexed 7-segment display controller.
- Samples the active-low segment bus `seg[0:6]` and the active-low one-hot anode bus `an[3:0]`, as driven onto the board pins.
- Rebuilds the four displayed 4-bit digits and flags blank or unrecognised patterns.
- Used for loopback self-test of the display path and for reading displays driven by external boards.
- Publishes one complete frame once all four digit positions have been captured.

Parameters:
- STABLE, default 16: consecutive identical samples needed before a digit is accepted (range 2..255).
- HEX, default 1: 1 decodes A,b,C,d,E,F; 0 treats those patterns as errors.
- TO_BITS, default 24: width of the frame watchdog counter (used only with the optional feature).

Ports:
- ck  in  1  system clock
- rst  in  1  synchronous active-high reset
- seg  in  7 [0:6]  segment bus, active-low, seg[0]=a … seg[6]=g
- an  in  4  anode bus, active-low; an[0] is the rightmost digit
- x3  out  4  captured leftmost digit
- x2  out  4  captured digit
- x1  out  4  captured digit
- x0  out  4  captured rightmost digit
- blank  out  4  per-digit flag, pattern was 1111111; bit i corresponds to xi
- err  out  4  per-digit flag, pattern was not recognised
- frame_valid  out  1  one-cycle pulse; x*/blank/err were updated this cycle
- an_err  out  1  sticky; set when more than one anode is active during a stable window
- stale  out  1  watchdog flag (optional feature)

Behaviour:
- Reset (rst=1 at posedge ck):
  - x3..x0=0, blank=0, err=0, frame_valid=0, an_err=0, stale=0.
  - Capture mask=0, stability counter=0, input pipeline=all ones (idle).
- Input pipeline: two register stages on {an,seg}; the second stage is the sample S.
- Stability counter:
  - Counts consecutive cycles with S equal to its previous value.
  - Resets to 0 on any change.
  - Saturates at STABLE.
  - A window is accepted on the cycle the counter first reaches STABLE-1, i.e. after STABLE equal samples. At most one acceptance per window.
- Anode decode at acceptance:
  - an=1111: no digit is active; ignored.
  - Exactly one bit low: slot i is selected.
  - More than one bit low: set an_err; no capture.
- Segment decode (pattern → value):
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4
  - 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0000100→9
  - HEX=1 only: 0001000→A, 1100000→b, 0110001→C, 1000010→d, 0110000→E, 0111000→F
  - 1111111: value 0, blank=1
  - Anything else, including 1111110 ("-"): value 0, err=1
- Capture:
  - The decoded value and flags go into shadow slot i; mask[i] is set.
  - Recapturing a slot before the frame completes overwrites that slot.
- Frame:
  - In the cycle after mask becomes 1111, the shadow registers are copied to x*/blank/err, frame_valid=1, and mask clears.
  - If an acceptance lands in that same cycle, it writes its shadow slot and sets its bit in the new mask, so no capture is lost.
- Latency: a digit held steady for STABLE cycles is accepted 2+STABLE-1 cycles after the pins change. A frame appears 1 cycle after the last slot is accepted.
- Outputs are registered and hold between frames.
- Reset mid-frame discards partial captures.
- an_err is cleared only by rst.

Optional Feature:
- Macro: SEG_CAPTURE_TIMEOUT_EN.
- Defined:
  - A TO_BITS-wide counter increments every cycle and clears on frame_valid.
  - When it reaches all ones: stale=1, mask clears, counter wraps to 0.
  - stale clears on the next frame_valid.
- Undefined: no counter is built; stale is tied to 0.

Test Plan:
- Digits 1,2,3,4 on an 1110/1101/1011/0111, each held 40 cycles, STABLE=16 → frame_valid once with x3=4, x2=3, x1=2, x0=1; blank=0, err=0.
- seg=0001000 on all digits, HEX=1 → x*=A, err=0. Same with HEX=0 → x*=0, err=1111.
- Digit 3 held at 1111111, others 0 → x3=0, blank=1000. A "-" on digit 0 → err=0001.
- Glitch: each digit held 10 cycles (<STABLE) → no frame_valid. Switch to 20-cycle holds → frame_valid after the fourth accepted slot.
- an=1100 held 20 cycles → an_err=1; no slot captured. rst → an_err=0.
- Macro defined, TO_BITS=8, only 3 digits driven → stale=1 after 255 cycles. Then drive all 4 → frame_valid=1, stale=0.

Source files
------------

// File: rtl/seg_capture.sv
// seg_capture: rebuilds four digits from a multiplexed active-low 7-segment/anode bus.
// Optional frame watchdog enabled by defining SEG_CAPTURE_TIMEOUT_EN.
module seg_capture #(
    parameter int STABLE  = 16,
    parameter int HEX     = 1,
    parameter int TO_BITS = 24
) (
    input  logic       ck,
    input  logic       rst,
    input  logic [0:6] seg,
    input  logic [3:0] an,
    output logic [3:0] x3,
    output logic [3:0] x2,
    output logic [3:0] x1,
    output logic [3:0] x0,
    output logic [3:0] blank,
    output logic [3:0] err,
    output logic       frame_valid,
    output logic       an_err,
    output logic       stale
);
    localparam int CW = $clog2(STABLE + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE);
    localparam logic [CW-1:0] CNT_ACC = CW'(STABLE - 1);

    typedef struct packed {
        logic [3:0] val;
        logic       blank;
        logic       err;
    } dec_t;

    // Patterns are written a..g, so seg[0] (segment a) is the leftmost bit.
    function automatic dec_t decode(input logic [6:0] p);
        dec_t d;
        d = '{val: 4'h0, blank: 1'b0, err: 1'b0};
        case (p)
            7'b0000001: d.val = 4'h0;
            7'b1001111: d.val = 4'h1;
            7'b0010010: d.val = 4'h2;
            7'b0000110: d.val = 4'h3;
            7'b1001100: d.val = 4'h4;
            7'b0100100: d.val = 4'h5;
            7'b0100000: d.val = 4'h6;
            7'b0001111: d.val = 4'h7;
            7'b0000000: d.val = 4'h8;
            7'b0000100: d.val = 4'h9;
            7'b0001000: if (HEX != 0) d.val = 4'hA; else d.err = 1'b1;
            7'b1100000: if (HEX != 0) d.val = 4'hB; else d.err = 1'b1;
            7'b0110001: if (HEX != 0) d.val = 4'hC; else d.err = 1'b1;
            7'b1000010: if (HEX != 0) d.val = 4'hD; else d.err = 1'b1;
            7'b0110000: if (HEX != 0) d.val = 4'hE; else d.err = 1'b1;
            7'b0111000: if (HEX != 0) d.val = 4'hF; else d.err = 1'b1;
            7'b1111111: d.blank = 1'b1;
            default:    d.err = 1'b1;
        endcase
        return d;
    endfunction

    logic [10:0]      p1_q, s_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       mask_q, mask_d;
    logic [3:0][3:0]  sh_x_q, x_q;
    logic [3:0]       sh_b_q, sh_e_q, blank_q, err_q;
    logic             fv_q, an_err_q;
    logic             accept, cap_en, multi, frame, timeout;
    logic [3:0]       an_s;
    logic [1:0]       idx;
    dec_t             dec;

    // p1_q is the value S takes at the next edge, so decisions use it directly.
    always_comb begin
        cnt_d = cnt_q;
        if (p1_q != s_q)
            cnt_d = '0;
        else if (cnt_q != CNT_MAX)
            cnt_d = cnt_q + 1'b1;
        accept = (cnt_d == CNT_ACC) && (cnt_q != CNT_ACC);

        an_s = p1_q[10:7];
        dec  = decode(p1_q[6:0]);
        idx  = 2'd0;
        for (int i = 0; i < 4; i++)
            if (!an_s[i]) idx = 2'(i);
        cap_en = accept && $onehot(~an_s);
        multi  = accept && (an_s != 4'hF) && !$onehot(~an_s);

        frame  = (mask_q == 4'hF);
        mask_d = mask_q;
        if (frame || timeout)
            mask_d = 4'h0;
        if (cap_en)
            mask_d[idx] = 1'b1;
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            p1_q     <= '1;
            s_q      <= '1;
            cnt_q    <= '0;
            mask_q   <= 4'h0;
            sh_x_q   <= '0;
            sh_b_q   <= 4'h0;
            sh_e_q   <= 4'h0;
            x_q      <= '0;
            blank_q  <= 4'h0;
            err_q    <= 4'h0;
            fv_q     <= 1'b0;
            an_err_q <= 1'b0;
        end else begin
            p1_q   <= {an, seg};
            s_q    <= p1_q;
            cnt_q  <= cnt_d;
            mask_q <= mask_d;
            fv_q   <= frame;
            if (frame) begin
                x_q     <= sh_x_q;
                blank_q <= sh_b_q;
                err_q   <= sh_e_q;
            end
            if (cap_en) begin
                sh_x_q[idx] <= dec.val;
                sh_b_q[idx] <= dec.blank;
                sh_e_q[idx] <= dec.err;
            end
            if (multi)
                an_err_q <= 1'b1;
        end
    end

`ifdef SEG_CAPTURE_TIMEOUT_EN
    logic [TO_BITS-1:0] to_q;
    logic               stale_q;

    assign timeout = &to_q;

    always_ff @(posedge ck) begin
        if (rst) begin
            to_q    <= '0;
            stale_q <= 1'b0;
        end else begin
            to_q <= fv_q ? '0 : to_q + 1'b1;
            if (frame)
                stale_q <= 1'b0;
            if (timeout)
                stale_q <= 1'b1;
        end
    end

    assign stale = stale_q;
`else
    assign timeout = 1'b0;
    assign stale   = 1'b0;
`endif

    assign x3          = x_q[3];
    assign x2          = x_q[2];
    assign x1          = x_q[1];
    assign x0          = x_q[0];
    assign blank       = blank_q;
    assign err         = err_q;
    assign frame_valid = fv_q;
    assign an_err      = an_err_q;
endmodule

// File: tb/tb_seg_capture.sv
// Bench for seg_capture: run-length/lookup-table model checked every cycle on a HEX=1
// and a HEX=0 instance sharing the same pins, plus literal frame expectations.
module tb_seg_capture;
    localparam int STABLE = 16;
    localparam int TB_TO  = 8;

    logic       ck = 1'b0;
    logic       rst;
    logic [0:6] seg_r;
    logic [3:0] an_r;

    logic [3:0] x3_1, x2_1, x1_1, x0_1, bl_1, er_1;
    logic       fv_1, ae_1, st_1;
    logic [3:0] x3_0, x2_0, x1_0, x0_0, bl_0, er_0;
    logic       fv_0, ae_0, st_0;

    always #5 ck = ~ck;

    seg_capture #(.STABLE(STABLE), .HEX(1), .TO_BITS(TB_TO)) dut1 (
        .ck(ck), .rst(rst), .seg(seg_r), .an(an_r),
        .x3(x3_1), .x2(x2_1), .x1(x1_1), .x0(x0_1),
        .blank(bl_1), .err(er_1), .frame_valid(fv_1), .an_err(ae_1), .stale(st_1));

    seg_capture #(.STABLE(STABLE), .HEX(0), .TO_BITS(TB_TO)) dut0 (
        .ck(ck), .rst(rst), .seg(seg_r), .an(an_r),
        .x3(x3_0), .x2(x2_0), .x1(x1_0), .x0(x0_0),
        .blank(bl_0), .err(er_0), .frame_valid(fv_0), .an_err(ae_0), .stale(st_0));

    // Segment patterns (a..g) for values 0..F.
    logic [6:0] SEGP [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] DASH  = 7'b1111110;

    typedef struct {
        logic [10:0] p1, s;
        int          run;
        logic [3:0]  mask;
        logic [15:0] shx;
        logic [3:0]  shb, she;
        logic [15:0] x;
        logic [3:0]  blank, err;
        logic        fv, an_err, stale;
        int          to;
    } mdl_t;

    mdl_t m1, m0;

    function automatic logic [5:0] mdl_dec(input logic [6:0] p, input bit hex);
        for (int i = 0; i < 16; i++)
            if ((i < 10 || hex) && p == SEGP[i]) return {4'(i), 2'b00};
        if (p == BLANK) return 6'b0000_10;
        return 6'b0000_01;
    endfunction

    // Sample S is the pin value two edges old; a window is taken when it has been
    // seen STABLE times in a row, once per window.
    function automatic mdl_t mdl_step(input mdl_t m, input logic [10:0] pins,
                                      input logic r, input bit hex);
        mdl_t n;
        logic [5:0] d;
        int nlow, sel;
        n = m;
        if (r) begin
            n.p1 = '1; n.s = '1; n.run = 1; n.mask = 0; n.shx = 0; n.shb = 0; n.she = 0;
            n.x = 0; n.blank = 0; n.err = 0; n.fv = 0; n.an_err = 0; n.stale = 0; n.to = 0;
            return n;
        end
        n.s  = m.p1;
        n.p1 = pins;
        if (n.s == m.s) n.run = (m.run < STABLE) ? m.run + 1 : m.run;
        else            n.run = 1;
        n.fv = (m.mask == 4'hF);
        if (n.fv) begin
            n.x = m.shx; n.blank = m.shb; n.err = m.she; n.mask = 0;
        end
`ifdef SEG_CAPTURE_TIMEOUT_EN
        n.to = m.fv ? 0 : (m.to + 1) % (1 << TB_TO);
        if (n.fv) n.stale = 1'b0;
        if (m.to == (1 << TB_TO) - 1) begin
            n.stale = 1'b1; n.mask = 0;
        end
`else
        n.stale = 1'b0;
`endif
        if (n.run == STABLE && m.run != STABLE) begin
            nlow = 0; sel = 0;
            for (int i = 0; i < 4; i++)
                if (!n.s[7+i]) begin nlow++; sel = i; end
            if (nlow == 1) begin
                d = mdl_dec(n.s[6:0], hex);
                n.shx[sel*4 +: 4] = d[5:2];
                n.shb[sel] = d[1];
                n.she[sel] = d[0];
                n.mask[sel] = 1'b1;
            end else if (nlow > 1) begin
                n.an_err = 1'b1;
            end
        end
        return n;
    endfunction

    always @(posedge ck) begin
        m1 = mdl_step(m1, {an_r, seg_r}, rst, 1'b1);
        m0 = mdl_step(m0, {an_r, seg_r}, rst, 1'b0);
    end

    int tests = 0, fails = 0, nfr = 0;
    logic [15:0] lx1, lx0;
    logic [3:0]  lb1, le1, le0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40) $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge ck);
        chk("x1",  {x3_1, x2_1, x1_1, x0_1}, m1.x);
        chk("bl1", bl_1, m1.blank);
        chk("er1", er_1, m1.err);
        chk("fv1", fv_1, m1.fv);
        chk("ae1", ae_1, m1.an_err);
        chk("st1", st_1, m1.stale);
        chk("x0",  {x3_0, x2_0, x1_0, x0_0}, m0.x);
        chk("er0", er_0, m0.err);
        chk("fv0", fv_0, m0.fv);
        if (fv_1) begin
            nfr++;
            lx1 = {x3_1, x2_1, x1_1, x0_1}; lb1 = bl_1; le1 = er_1;
        end
        if (fv_0) begin
            lx0 = {x3_0, x2_0, x1_0, x0_0}; le0 = er_0;
        end
    endtask

    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
        an_r  = a;
        seg_r = s;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        an_r = 4'hF; seg_r = BLANK;
        tick(); tick();
        rst = 1'b0;
        nfr = 0;
    endtask

    // One value per slot, slot 0 (an=1110) first.
    task automatic four(input logic [6:0] s0, input logic [6:0] s1,
                        input logic [6:0] s2, input logic [6:0] s3, input int n);
        hold(4'b1110, s0, n);
        hold(4'b1101, s1, n);
        hold(4'b1011, s2, n);
        hold(4'b0111, s3, n);
    endtask

    initial begin
        rst = 1'b1; an_r = 4'hF; seg_r = BLANK;
        do_reset();
        chk("rst_x",  {x3_1, x2_1, x1_1, x0_1}, 16'h0);
        chk("rst_fl", {bl_1, er_1}, 8'h0);
        chk("rst_ae", {fv_1, ae_1, st_1}, 3'b000);

        // Digits 1..4, 40-cycle holds.
        four(SEGP[1], SEGP[2], SEGP[3], SEGP[4], 40);
        hold(4'hF, BLANK, 10);
        chk("t1_nfr", nfr, 1);
        chk("t1_x", lx1, 16'h4321);
        chk("t1_fl", {lb1, le1}, 8'h00);
        chk("t1_mdl", m1.x, 16'h4321);

        // Pattern A on every slot, HEX on and off.
        do_reset();
        four(SEGP[10], SEGP[10], SEGP[10], SEGP[10], 20);
        hold(4'hF, BLANK, 5);
        chk("t2_x1", lx1, 16'hAAAA);
        chk("t2_e1", le1, 4'h0);
        chk("t2_x0", lx0, 16'h0000);
        chk("t2_e0", le0, 4'hF);

        // Blank on slot 3, dash on slot 0.
        do_reset();
        four(DASH, SEGP[0], SEGP[0], BLANK, 20);
        hold(4'hF, BLANK, 5);
        chk("t3_x", lx1, 16'h0000);
        chk("t3_bl", lb1, 4'b1000);
        chk("t3_er", le1, 4'b0001);

        // Short holds never accepted, then proper holds give one frame.
        do_reset();
        four(SEGP[5], SEGP[6], SEGP[7], SEGP[8], 10);
        four(SEGP[5], SEGP[6], SEGP[7], SEGP[8], 10);
        chk("t4_glitch", nfr, 0);
        four(SEGP[5], SEGP[6], SEGP[7], SEGP[8], 20);
        hold(4'hF, BLANK, 5);
        chk("t4_nfr", nfr, 1);
        chk("t4_x", lx1, 16'h8765);

        // Two anodes low: an_err, no slot taken.
        do_reset();
        hold(4'b1100, SEGP[9], 20);
        chk("t5_ae", ae_1, 1'b1);
        hold(4'b1101, SEGP[1], 20);
        hold(4'b1011, SEGP[2], 20);
        hold(4'b0111, SEGP[3], 20);
        chk("t5_noslot", nfr, 0);
        hold(4'b1110, SEGP[9], 20);
        chk("t5_nfr", nfr, 1);
        chk("t5_x", lx1, 16'h3219);
        chk("t5_ae_sticky", ae_1, 1'b1);
        do_reset();
        chk("t5_ae_rst", ae_1, 1'b0);

`ifdef SEG_CAPTURE_TIMEOUT_EN
        // Only three slots driven: watchdog fires, then a full frame clears it.
        do_reset();
        hold(4'b1110, SEGP[1], 20);
        hold(4'b1101, SEGP[2], 20);
        hold(4'b1011, SEGP[3], 20);
        hold(4'hF, BLANK, 220);
        chk("t6_stale", st_1, 1'b1);
        chk("t6_nfr0", nfr, 0);
        four(SEGP[1], SEGP[2], SEGP[3], SEGP[4], 20);
        hold(4'hF, BLANK, 5);
        chk("t6_nfr", nfr, 1);
        chk("t6_clr", st_1, 1'b0);
`else
        hold(4'hF, BLANK, 300);
        chk("t6_nostale", st_1, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
